// File: rtl/aes_encrypt_iter_pkg.sv
// rtl/aes_encrypt_iter_pkg.sv - shared constants, FSM encoding and GF(2^8) helpers for the AES core
package aes_encrypt_iter_pkg;

   localparam int AES_NR    = 10;
   localparam int AES_BLK_W = 128;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fsm_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box as multiplicative inverse (b^254, with 0 -> 0) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = b;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_encrypt_iter_round.sv
// rtl/aes_encrypt_iter_round.sv - one combinational AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey
module aes_encrypt_iter_round
   import aes_encrypt_iter_pkg::*;
(
   input  logic [AES_BLK_W-1:0] state_i,
   input  logic [AES_BLK_W-1:0] rk_i,
   input  logic                 last_i,
   output logic [AES_BLK_W-1:0] state_o
);

   logic [AES_BLK_W-1:0] sb_w;
   logic [AES_BLK_W-1:0] sr_w;
   logic [AES_BLK_W-1:0] mc_w;

   // Byte (column c, row r) lives at [32c+24-8r +: 8]; row 0 is the column MSB
   always_comb begin
      sb_w = '0;
      sr_w = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sb_w[32*c+24-8*r +: 8] = sbox(state_i[32*c+24-8*r +: 8]);
         end
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr_w[32*c+24-8*r +: 8] = sb_w[32*((c+r)%4)+24-8*r +: 8];
         end
      end
   end

   always_comb begin
      logic [7:0] a0, a1, a2, a3;
      mc_w = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = sr_w[32*c+24 +: 8];
         a1 = sr_w[32*c+16 +: 8];
         a2 = sr_w[32*c+8  +: 8];
         a3 = sr_w[32*c    +: 8];
         mc_w[32*c+24 +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         mc_w[32*c+16 +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         mc_w[32*c+8  +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         mc_w[32*c    +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
   end

   assign state_o = (last_i ? sr_w : mc_w) ^ rk_i;

endmodule

// File: rtl/aes_encrypt_iter.sv
// rtl/aes_encrypt_iter.sv - iterative AES-128 encryption core, one round per clock, valid/ready on both sides
module aes_encrypt_iter
   import aes_encrypt_iter_pkg::*;
#(
   parameter int NR = AES_NR
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [AES_BLK_W-1:0]          plaintext,
   input  logic [AES_BLK_W*(NR+1)-1:0]   subkeys,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [AES_BLK_W-1:0]          ciphertext,
   output logic                          busy
);

   localparam logic [3:0] NR_L = 4'(NR);

   fsm_e                 fsm_q, fsm_d;
   logic [3:0]           rnd_q, rnd_d;
   logic [AES_BLK_W-1:0] data_q, data_d;
   logic                 up_q;
   logic [AES_BLK_W-1:0] rk_sel;
   logic [AES_BLK_W-1:0] round_out;
   logic                 last_rnd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q  <= ST_IDLE;
         rnd_q  <= 4'd0;
         data_q <= '0;
         up_q   <= 1'b0;
      end else begin
         fsm_q  <= fsm_d;
         rnd_q  <= rnd_d;
         data_q <= data_d;
         up_q   <= 1'b1;
      end
   end

   // Round keys are not latched: the bus must hold steady for the whole block
   always_comb begin
      rk_sel = '0;
      for (int r = 0; r <= NR; r++) begin
         if (rnd_q == 4'(r)) rk_sel = subkeys[AES_BLK_W*r +: AES_BLK_W];
      end
   end

   assign last_rnd = (rnd_q == NR_L);

   aes_encrypt_iter_round u_round (
      .state_i (data_q),
      .rk_i    (rk_sel),
      .last_i  (last_rnd),
      .state_o (round_out)
   );

   always_comb begin
      fsm_d      = fsm_q;
      rnd_d      = rnd_q;
      data_d     = data_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      ciphertext = '0;
      case (fsm_q)
         ST_IDLE: begin
            // up_q keeps in_ready low until the first clock after reset release
            in_ready = up_q;
            if (in_valid && up_q) begin
               data_d = plaintext ^ subkeys[AES_BLK_W-1:0];
               rnd_d  = 4'd1;
               fsm_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            busy   = 1'b1;
            data_d = round_out;
            if (last_rnd) begin
               fsm_d = ST_DONE;
            end else begin
               rnd_d = rnd_q + 4'd1;
            end
         end
         ST_DONE: begin
            out_valid  = 1'b1;
            ciphertext = data_q;
            if (out_ready) fsm_d = ST_IDLE;
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb/tb_aes_encrypt_iter.sv - directed and randomized checks of aes_encrypt_iter against a byte-level AES model
module tb_aes_encrypt_iter;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [127:0]  plaintext;
   logic [1407:0] subkeys;
   logic          out_valid;
   logic          out_ready;
   logic [127:0]  ciphertext;
   logic          busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int           acc_cyc[$];
   logic [127:0] acc_pt[$];
   logic [127:0] out_ct[$];

   logic [7:0] sbox_tab [256];

   aes_encrypt_iter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plaintext  (plaintext),
      .subkeys    (subkeys),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ciphertext (ciphertext),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (in_valid && in_ready) begin
         acc_cyc.push_back(cyc);
         acc_pt.push_back(plaintext);
      end
      if (out_valid && out_ready) out_ct.push_back(ciphertext);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int rotl8(input int v, input int s);
      return ((v << s) | (v >> (8 - s))) & 255;
   endfunction

   function automatic int m2(input int x);
      return ((x << 1) ^ ((x >> 7) * 27)) & 255;
   endfunction

   task automatic build_sbox();
      int p = 1;
      int q = 1;
      int x;
      do begin
         p = (p ^ (p << 1) ^ (((p & 128) != 0) ? 27 : 0)) & 255;
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         q = q & 255;
         if ((q & 128) != 0) q = q ^ 9;
         x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
         sbox_tab[p] = 8'(x ^ 99);
      end while (p != 1);
      sbox_tab[0] = 8'h63;
   endtask

   // FIPS text order (word0 first, leftmost) to bus order (word0 in the LSBs)
   function automatic logic [127:0] fips2bus(input logic [127:0] x);
      logic [127:0] r;
      for (int i = 0; i < 4; i++) r[32*i +: 32] = x[127-32*i -: 32];
      return r;
   endfunction

   function automatic logic [1407:0] expand(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [1407:0] ks;
      int rc = 1;
      for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
            t = t ^ {8'(rc), 24'h0};
            rc = m2(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 44; i++) ks[32*i +: 32] = w[i];
      return ks;
   endfunction

   function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [1407:0] ks);
      int s[16];
      int t[16];
      int a0, a1, a2, a3;
      logic [127:0] r;
      for (int c = 0; c < 4; c++)
         for (int rw = 0; rw < 4; rw++)
            s[4*c+rw] = int'(pt[32*c+24-8*rw +: 8] ^ ks[32*c+24-8*rw +: 8]);
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) t[i] = int'(sbox_tab[s[i]]);
         for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
               s[4*c+rw] = t[4*((c+rw)%4)+rw];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
               s[4*c+3] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
            end
         end
         for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
               s[4*c+rw] = s[4*c+rw] ^ int'(ks[128*rnd + 32*c+24-8*rw +: 8]);
      end
      for (int c = 0; c < 4; c++)
         for (int rw = 0; rw < 4; rw++)
            r[32*c+24-8*rw +: 8] = 8'(s[4*c+rw]);
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accept(input int n_target);
      int n = 0;
      while (acc_cyc.size() < n_target && n < 40) begin
         tick();
         n++;
      end
      check("accept_seen", 128'(acc_cyc.size() >= n_target), 128'd1);
   endtask

   task automatic send_wait(input logic [127:0] pt, input logic [1407:0] ks, output int lat);
      int n0;
      n0 = acc_cyc.size();
      subkeys   = ks;
      plaintext = pt;
      in_valid  = 1'b1;
      wait_accept(n0 + 1);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic drain(input string tag, input logic [127:0] exp);
      int n0;
      int n = 0;
      n0 = out_ct.size();
      while (out_ct.size() == n0 && n < 40) begin
         tick();
         n++;
      end
      check(tag, (out_ct.size() > n0) ? out_ct[$] : 128'hx, exp);
   endtask

   initial begin
      logic [127:0]  key, pt, pt2, held;
      logic [1407:0] ks;
      int lat, n0, n;

      build_sbox();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      plaintext = '0;
      subkeys   = '0;
      tick();
      tick();
      check("rst_in_ready",   128'(in_ready),  128'd0);
      check("rst_out_valid",  128'(out_valid), 128'd0);
      check("rst_busy",       128'(busy),      128'd0);
      check("rst_ciphertext", ciphertext,      128'd0);
      rst_n = 1'b1;
      #1;
      check("in_ready_after_release", 128'(in_ready), 128'd0);
      tick();
      check("in_ready_first_clock", 128'(in_ready), 128'd1);

      // FIPS-197 App.B
      ks = expand(fips2bus(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c));
      send_wait(fips2bus(128'h3243f6a8_885a308d_313198a2_e0370734), ks, lat);
      check("fipsB_latency", 128'(lat), 128'd10);
      check("fipsB_busy_done", 128'(busy), 128'd0);
      drain("fipsB_ct", fips2bus(128'h3925841d_02dc09fb_dc118597_196a0b32));

      // FIPS-197 App.C.1
      ks = expand(fips2bus(128'h00010203_04050607_08090a0b_0c0d0e0f));
      send_wait(fips2bus(128'h00112233_44556677_8899aabb_ccddeeff), ks, lat);
      check("fipsC1_latency", 128'(lat), 128'd10);
      drain("fipsC1_ct", fips2bus(128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a));

      // randomized blocks against the model
      for (int k = 0; k < 4; k++) begin
         key = rnd128();
         pt  = rnd128();
         ks  = expand(key);
         send_wait(pt, ks, lat);
         check("rand_latency", 128'(lat), 128'd10);
         drain("rand_ct", ref_enc(pt, ks));
      end

      // stall: out_ready low for 5 cycles after out_valid
      key = rnd128();
      pt  = rnd128();
      ks  = expand(key);
      out_ready = 1'b0;
      send_wait(pt, ks, lat);
      held = ref_enc(pt, ks);
      n0 = out_ct.size();
      for (int k = 0; k < 5; k++) begin
         check("stall_out_valid", 128'(out_valid), 128'd1);
         check("stall_ct",        ciphertext,      held);
         check("stall_in_ready",  128'(in_ready),  128'd0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("stall_released", (out_ct.size() == n0 + 1) ? out_ct[$] : 128'hx, held);
      check("stall_idle_ready", 128'(in_ready), 128'd1);

      // back-to-back with in_valid held high
      key = rnd128();
      pt  = rnd128();
      pt2 = rnd128();
      ks  = expand(key);
      subkeys = ks;
      n0 = acc_cyc.size();
      plaintext = pt;
      in_valid  = 1'b1;
      wait_accept(n0 + 1);
      plaintext = pt2;
      wait_accept(n0 + 2);
      in_valid = 1'b0;
      check("b2b_spacing", 128'(acc_cyc[$] - acc_cyc[$-1]), 128'd12);
      n = 0;
      while (out_ct.size() < (n0 + 2 - 0) + (out_ct.size() - acc_cyc.size() + 2) - 2 && n < 0) n++;
      drain("b2b_ct2", ref_enc(pt2, ks));
      check("b2b_ct1", out_ct[$-1], ref_enc(pt, ks));

      // reset at T0+5
      key = rnd128();
      pt  = rnd128();
      ks  = expand(key);
      subkeys = ks;
      n0 = acc_cyc.size();
      plaintext = pt;
      in_valid  = 1'b1;
      wait_accept(n0 + 1);
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      n0 = out_ct.size();
      rst_n = 1'b0;
      #1;
      check("midrst_busy",       128'(busy),      128'd0);
      check("midrst_out_valid",  128'(out_valid), 128'd0);
      check("midrst_in_ready",   128'(in_ready),  128'd0);
      check("midrst_ciphertext", ciphertext,      128'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("midrst_ready_back", 128'(in_ready), 128'd1);
      for (int k = 0; k < 12; k++) tick();
      check("midrst_no_output", 128'(out_ct.size()), 128'(n0));
      pt = rnd128();
      send_wait(pt, ks, lat);
      check("postrst_latency", 128'(lat), 128'd10);
      drain("postrst_ct", ref_enc(pt, ks));

      // in_valid with changing plaintext while busy
      key = rnd128();
      pt  = rnd128();
      ks  = expand(key);
      subkeys = ks;
      n0 = acc_cyc.size();
      plaintext = pt;
      in_valid  = 1'b1;
      wait_accept(n0 + 1);
      for (int k = 0; k < 6; k++) begin
         plaintext = rnd128();
         check("busy_flag",      128'(busy),     128'd1);
         check("busy_in_ready",  128'(in_ready), 128'd0);
         tick();
      end
      in_valid = 1'b0;
      drain("busy_ignore_ct", ref_enc(pt, ks));
      check("busy_single_accept", 128'(acc_cyc.size()), 128'(n0 + 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
